uart_tx_arbiter: RTL and testbench

Packet-locked round-robin arbiter that shares the single harness UART transmitter (driving `uart_txd`) among `N_REQ` on-chip byte-stream requesters (e.g. core console, debug monitor, DDR-calibration status reporter). A grant is held for a whole packet, terminated by `req_last`, so messages never interleave mid-line. A stall watchdog reclaims the grant from a stuck requester. The block sits between the requesters and the UART TX serializer, with one registered output stage.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Width of a requester index; never below one bit.
    function automatic int grant_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after last_grant
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = grant_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic          found,
    output logic [GW-1:0] index
);

    logic [GW-1:0] start;
    logic [N-1:0]  rotated;
    int            pos;

    // Rotate so the slot after last_grant lands on bit 0, take the lowest set
    // bit, then map that offset back to an absolute requester index.
    always_comb begin
        start   = (last_grant == GW'(N - 1)) ? '0 : last_grant + 1'b1;
        rotated = N'({req, req} >> start);
        found   = |rotated;
        index   = '0;
        pos     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                pos = int'(start) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                index = GW'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter in front of the UART TX
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int GRANT_W = grant_w(N_REQ),
    localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [GRANT_W-1:0]      grant_id,
    output logic                    busy,
    output logic                    timeout_pulse
);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [GRANT_W-1:0]  last_grant;
    logic [CNT_W-1:0]    stall_cnt;
    logic                pick_found;
    logic [GRANT_W-1:0]  pick_index;
    logic                can_accept;
    logic                g_valid;
    logic                g_last;
    logic [DATA_W-1:0]   g_data;
    logic                xfer;
    logic                wd_fire;

    rr_pick #(
        .N  (N_REQ),
        .GW (GRANT_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_index)
    );

    // Grantee view: handshake qualifier and watchdog expiry for this cycle.
    always_comb begin
        can_accept = !tx_valid || tx_ready;
        g_valid    = req_valid[grant_id];
        g_last     = req_last[grant_id];
        g_data     = req_data[grant_id*DATA_W +: DATA_W];
        xfer       = (state == LOCKED) && g_valid && can_accept;
        wd_fire    = (TIMEOUT != 0) && (state == LOCKED) && !g_valid
                     && (stall_cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: lock on any request, release on last beat or watchdog.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if ((xfer && g_last) || wd_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: only the grantee sees ready, and only when the register can take a beat.
    always_comb begin
        busy      = (state == LOCKED);
        req_ready = '0;
        if (state == LOCKED) begin
            req_ready[grant_id] = can_accept;
        end
    end

    // Grant bookkeeping, watchdog counter and the single output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant    <= GRANT_W'(N_REQ - 1);
            grant_id      <= '0;
            stall_cnt     <= '0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= wd_fire;

            if (state == IDLE && pick_found) begin
                grant_id <= pick_index;
            end

            if ((xfer && g_last) || wd_fire) begin
                last_grant <= grant_id;
            end

            if (state == IDLE || xfer || wd_fire) begin
                stall_cnt <= '0;
            end else if (!g_valid && TIMEOUT != 0) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (xfer) begin
                tx_data  <= g_data;
                tx_valid <= 1'b1;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [W-1:0]   tx_data;
    logic           tx_ready = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_pulse;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .DATA_W  (W),
        .TIMEOUT (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Requester packet stores: {last, data}
    logic [8:0]   mem [N][64];
    int           head [N];
    int           tail [N];
    logic [N-1:0] hs = '0;
    int           rdy_mode = 1;

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) return 0;
        end
        return 1;
    endfunction

    always @(negedge clock) hs = req_valid & req_ready;

    // Requester and UART-side drivers, updated just after each active edge.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && head[i] < tail[i]) head[i]++;
            if (head[i] < tail[i]) begin
                req_valid[i]         = 1'b1;
                req_data[i*W +: W]   = mem[i][head[i]][7:0];
                req_last[i]          = mem[i][head[i]][8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Behavioural model: arbitration by modular scan, stall counting, one-deep output.
    bit         m_locked, m_tv, m_to, can_m, done_m, v_m;
    int         m_g, m_last, m_stall, c_m;
    logic [7:0] m_td;

    always @(posedge clock) begin
        if (reset) begin
            m_locked = 0; m_g = 0; m_last = N - 1; m_stall = 0;
            m_tv = 0; m_td = 0; m_to = 0;
        end else begin
            can_m = !m_tv || tx_ready;
            m_to  = 0;
            if (!m_locked) begin
                if (m_tv && tx_ready) m_tv = 0;
                done_m = 0;
                for (int k = 1; k <= N; k++) begin
                    c_m = (m_last + k) % N;
                    if (!done_m && req_valid[c_m]) begin
                        m_g = c_m; m_locked = 1; m_stall = 0; done_m = 1;
                    end
                end
            end else begin
                v_m = req_valid[m_g];
                if (v_m && can_m) begin
                    m_td = req_data[m_g*W +: W];
                    m_tv = 1;
                    m_stall = 0;
                    if (req_last[m_g]) begin
                        m_locked = 0; m_last = m_g;
                    end
                end else begin
                    if (m_tv && tx_ready) m_tv = 0;
                    if (!v_m) begin
                        m_stall++;
                        if (m_stall == TO) begin
                            m_locked = 0; m_last = m_g; m_to = 1; m_stall = 0;
                        end
                    end
                end
            end
        end
    end

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         grants [$];
    bit         busy_q = 0;

    // Per-cycle comparison against the model, plus delivered-beat and grant logs.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", busy, m_locked);
            chk("grant_id", grant_id, m_g);
            chk("tx_valid", tx_valid, m_tv);
            chk("tx_data", tx_data, m_td);
            chk("req_ready", req_ready,
                (m_locked && (!m_tv || tx_ready)) ? 32'(1 << m_g) : 32'd0);
            chk("timeout_pulse", timeout_pulse, m_to);
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (busy && !busy_q) grants.push_back(int'(grant_id));
            busy_q = busy;
        end
    end

    task automatic check_stream(input string name);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(all_empty() && !busy && !tx_valid) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: still active after %0d cycles", name, n);
        end
    endtask

    task automatic wait_beat(input logic [7:0] d, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(tx_valid && tx_data == d) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: beat %0h not seen within %0d cycles", name, d, n);
        end
    endtask

    initial begin
        clear_all();
        reset = 1'b1;
        rdy_mode = 1;
        repeat (2) @(posedge clock);
        chk_en = 1;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);

        // Single requester, three beats, latency pinned by hand
        reset = 1'b0;
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
        exp_q = '{8'h41, 8'h42, 8'h43};
        @(negedge clock); chk("t1_idle", busy, 0);
        @(negedge clock);
        chk("t1_grant", grant_id, 1);
        chk("t1_busy", busy, 1);
        chk("t1_ready", req_ready, 4'b0010);
        chk("t1_txv_low", tx_valid, 0);
        @(negedge clock); chk("t1_d0", tx_data, 8'h41); chk("t1_txv", tx_valid, 1);
        @(negedge clock); chk("t1_d1", tx_data, 8'h42);
        @(negedge clock); chk("t1_d2", tx_data, 8'h43); chk("t1_busy_end", busy, 0);
        @(negedge clock); chk("t1_drain", tx_valid, 0);
        check_stream("t1_stream");

        // Fairness: everyone has two 2-beat packets; last grant was 1
        grants.delete();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++)
                for (int b = 0; b < 2; b++)
                    push(r, 8'(r * 16 + p * 2 + b), 1'(b));
        for (int p = 0; p < 2; p++)
            for (int j = 0; j < N; j++)
                for (int b = 0; b < 2; b++)
                    exp_q.push_back(8'(((2 + j) % N) * 16 + p * 2 + b));
        wait_done(200, "fair_wait");
        chk("fair_grant_count", grants.size(), 8);
        for (int i = 0; i < grants.size() && i < 8; i++)
            chk("fair_order", grants[i], (2 + i) % N);
        check_stream("fair_stream");

        // Backpressure with random tx_ready
        rdy_mode = 2;
        for (int b = 0; b < 5; b++) push(0, 8'hA0 + 8'(b), 1'(b == 4));
        push(1, 8'hB0, 0); push(1, 8'hB1, 1);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB0, 8'hB1};
        wait_done(300, "bp_wait");
        rdy_mode = 1;
        check_stream("bp_stream");

        // Watchdog: req2 sends one non-last beat then goes quiet; req3 waits
        push(2, 8'hC0, 0);
        push(3, 8'hD0, 0); push(3, 8'hD1, 1);
        exp_q = '{8'hC0, 8'hD0, 8'hD1};
        wait_beat(8'hC0, 20, "wd_first_beat");
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            chk("wd_no_early_pulse", timeout_pulse, 0);
            chk("wd_locked", busy, 1);
        end
        @(negedge clock);
        chk("wd_pulse", timeout_pulse, 1);
        chk("wd_released", busy, 0);
        @(negedge clock);
        chk("wd_pulse_single", timeout_pulse, 0);
        chk("wd_next_grant", grant_id, 3);
        chk("wd_next_busy", busy, 1);
        wait_done(50, "wd_wait");
        check_stream("wd_stream");

        // Watchdog race: valid returns on the eighth stalled edge
        push(2, 8'hE0, 0);
        exp_q = '{8'hE0, 8'hE1};
        wait_beat(8'hE0, 20, "race_first_beat");
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chk("race_no_pulse", timeout_pulse, 0);
            if (k == 6) push(2, 8'hE1, 1);
            if (k < 8) chk("race_locked", busy, 1);
        end
        chk("race_beat", tx_data, 8'hE1);
        chk("race_done", busy, 0);
        wait_done(50, "race_wait");
        check_stream("race_stream");

        // Reset mid-packet while a beat is stuck in the output register
        rdy_mode = 0;
        for (int b = 0; b < 4; b++) push(1, 8'hF0 + 8'(b), 1'(b == 3));
        wait_beat(8'hF0, 20, "rst_first_beat");
        chk("rst_pending", tx_valid, 1);
        reset = 1'b1;
        clear_all();
        @(negedge clock);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_pulse", timeout_pulse, 0);
        reset = 1'b0;
        rdy_mode = 1;
        got_q.delete();
        grants.delete();
        push(3, 8'h30, 1);
        push(0, 8'h00, 1);
        exp_q = '{8'h00, 8'h30};
        wait_done(50, "rst_wait");
        chk("rst_grant_count", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("rst_first_winner", grants[0], 0);
            chk("rst_second_winner", grants[1], 3);
        end
        check_stream("rst_stream");

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

endmodule
